// File: rtl/regfile_mp.sv
// Multi-read-port register file with per-register pending scoreboard and write-to-read forwarding.
// Reads are combinational; after reset an INIT sweep clears registers 1..N-1, then ready goes high.
module regfile_mp #(
  parameter int REG_NUM_BITWIDTH = 5,
  parameter int WORD_BITWIDTH    = 32,
  parameter int NUM_READ         = 2,
  parameter int BYPASS           = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_READ*REG_NUM_BITWIDTH-1:0] rd_addr,
  output logic [NUM_READ*WORD_BITWIDTH-1:0]    rd_data,
  output logic [NUM_READ-1:0]                  rd_pending,
  input  logic                                 wr_en,
  input  logic [REG_NUM_BITWIDTH-1:0]          wr_addr,
  input  logic [WORD_BITWIDTH-1:0]             wr_data,
  input  logic                                 iss_en,
  input  logic [REG_NUM_BITWIDTH-1:0]          iss_addr,
  output logic                                 ready
);

  localparam int RB    = REG_NUM_BITWIDTH;
  localparam int W     = WORD_BITWIDTH;
  localparam int DEPTH = 2 ** RB;
  localparam logic [RB-1:0] LAST = RB'(DEPTH - 1);

  typedef enum logic {INIT, RUN} state_e;

  state_e          state_q;
  logic [RB-1:0]   cnt_q;
  logic            ready_q;
  logic [DEPTH-1:0] pend_q;
  logic [DEPTH-1:0] pend_d;
  logic [W-1:0]    mem_q [DEPTH];

  logic wr_fire;
  logic iss_fire;

  assign wr_fire  = (state_q == RUN) && wr_en  && (wr_addr  != '0);
  assign iss_fire = (state_q == RUN) && iss_en && (iss_addr != '0);
  assign ready    = ready_q;

  // Issue is applied after the write clear so a same-edge issue keeps the bit set.
  always_comb begin
    pend_d = pend_q;
    if (wr_fire) pend_d[wr_addr] = 1'b0;
    if (iss_fire) pend_d[iss_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= INIT;
      cnt_q   <= RB'(1);
      ready_q <= 1'b0;
      pend_q  <= '0;
    end else begin
      case (state_q)
        INIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q <= RUN;
            ready_q <= 1'b1;
          end
        end
        RUN: pend_q <= pend_d;
        default: state_q <= INIT;
      endcase
    end
  end

  // Storage is not reset; the INIT sweep clears it. Entry 0 is never written.
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_fire) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    logic [RB-1:0] a;
    logic          byp_hit;
    logic          iss_hit;
    rd_data    = '0;
    rd_pending = '0;
    a          = '0;
    byp_hit    = 1'b0;
    iss_hit    = 1'b0;
    for (int i = 0; i < NUM_READ; i++) begin
      a       = rd_addr[i*RB +: RB];
      byp_hit = (BYPASS != 0) && wr_fire && (wr_addr == a);
      iss_hit = iss_fire && (iss_addr == a);
      if ((state_q == RUN) && (a != '0)) begin
        rd_data[i*W +: W] = byp_hit ? wr_data : mem_q[a];
        rd_pending[i]     = (byp_hit && !iss_hit) ? 1'b0 : pend_q[a];
      end
    end
  end

endmodule
